// File: rtl/biriscv_bpred_pkg.sv
// Shared types for the branch predictor: BHT counter encodings, BTB field
// widths and the positions of the branch-type bits held per BTB entry.
package biriscv_bpred_pkg;

  typedef enum logic [1:0] {
    STRONG_NT = 2'd0,
    WEAK_NT   = 2'd1,
    WEAK_T    = 2'd2,
    STRONG_T  = 2'd3
  } bht_cnt_t;

  localparam bht_cnt_t BHT_RESET = WEAK_T;

  localparam int unsigned BTB_PC_W   = 32;
  localparam int unsigned BTB_TGT_W  = 32;
  localparam int unsigned BTB_TYPE_W = 3;

  localparam int unsigned TYPE_CALL = 0;
  localparam int unsigned TYPE_RET  = 1;
  localparam int unsigned TYPE_JMP  = 2;

  function automatic bht_cnt_t bht_update(input bht_cnt_t cnt, input logic taken);
    bht_cnt_t nxt;
    nxt = cnt;
    case (cnt)
      STRONG_NT: nxt = taken ? WEAK_NT  : STRONG_NT;
      WEAK_NT:   nxt = taken ? WEAK_T   : STRONG_NT;
      WEAK_T:    nxt = taken ? STRONG_T : WEAK_NT;
      STRONG_T:  nxt = taken ? STRONG_T : WEAK_T;
      default:   nxt = cnt;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/biriscv_bpred_if.sv
// Predictor bus: execute-stage resolutions in, fetch PC in, prediction out.
interface biriscv_bpred_if;
  logic        enable_i;
  logic        branch_request_i;
  logic        branch_is_taken_i;
  logic        branch_is_not_taken_i;
  logic [31:0] branch_source_i;
  logic [31:0] branch_pc_i;
  logic        branch_is_call_i;
  logic        branch_is_ret_i;
  logic        branch_is_jmp_i;
  logic [31:0] pc_f_i;
  logic [31:0] next_pc_f_o;
  logic        next_taken_f_o;

  modport master (
    output enable_i, branch_request_i, branch_is_taken_i, branch_is_not_taken_i,
           branch_source_i, branch_pc_i, branch_is_call_i, branch_is_ret_i,
           branch_is_jmp_i, pc_f_i,
    input  next_pc_f_o, next_taken_f_o
  );

  modport slave (
    input  enable_i, branch_request_i, branch_is_taken_i, branch_is_not_taken_i,
           branch_source_i, branch_pc_i, branch_is_call_i, branch_is_ret_i,
           branch_is_jmp_i, pc_f_i,
    output next_pc_f_o, next_taken_f_o
  );
endinterface

// File: rtl/biriscv_bpred_ras.sv
// Circular return address stack with saturating occupancy count; a full
// push silently overwrites the oldest entry.
module biriscv_bpred_ras #(
  parameter int unsigned NUM_RAS_ENTRIES   = 8,
  parameter int unsigned NUM_RAS_ENTRIES_W = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic [31:0] push_data_i,
  output logic [31:0] top_data_o,
  output logic        empty_o
);

  localparam logic [NUM_RAS_ENTRIES_W:0] RAS_FULL = NUM_RAS_ENTRIES[NUM_RAS_ENTRIES_W:0];

  logic [31:0]                  r_stack [NUM_RAS_ENTRIES];
  logic [NUM_RAS_ENTRIES_W-1:0] r_top;
  logic [NUM_RAS_ENTRIES_W:0]   r_count;
  logic [NUM_RAS_ENTRIES_W-1:0] w_top_inc;

  assign w_top_inc  = r_top + NUM_RAS_ENTRIES_W'(1);
  assign top_data_o = r_stack[r_top];
  assign empty_o    = (r_count == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NUM_RAS_ENTRIES; i++) r_stack[i] <= '0;
      r_top   <= '0;
      r_count <= '0;
    end else if (push_i && pop_i) begin
      // Pop followed by push collapses to replacing the top in place.
      r_stack[r_top] <= push_data_i;
    end else if (push_i) begin
      r_stack[w_top_inc] <= push_data_i;
      r_top              <= w_top_inc;
      if (r_count != RAS_FULL) r_count <= r_count + 1'b1;
    end else if (pop_i && r_count != '0) begin
      r_top   <= r_top - NUM_RAS_ENTRIES_W'(1);
      r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/biriscv_bpred.sv
// Fetch branch predictor: fully associative BTB, bimodal BHT and a RAS,
// looked up combinationally on the fetch PC and trained by execute resolutions.
module biriscv_bpred
  import biriscv_bpred_pkg::*;
#(
  parameter int unsigned NUM_BTB_ENTRIES   = 16,
  parameter int unsigned NUM_BTB_ENTRIES_W = 4,
  parameter int unsigned NUM_BHT_ENTRIES   = 256,
  parameter int unsigned NUM_BHT_ENTRIES_W = 8,
  parameter int unsigned NUM_RAS_ENTRIES   = 8,
  parameter int unsigned NUM_RAS_ENTRIES_W = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  biriscv_bpred_if.slave  bus
);

  logic                   r_btb_valid [NUM_BTB_ENTRIES];
  logic [BTB_PC_W-1:0]    r_btb_pc    [NUM_BTB_ENTRIES];
  logic [BTB_TGT_W-1:0]   r_btb_tgt   [NUM_BTB_ENTRIES];
  logic [BTB_TYPE_W-1:0]  r_btb_type  [NUM_BTB_ENTRIES];
  bht_cnt_t               r_bht       [NUM_BHT_ENTRIES];
  logic [NUM_BTB_ENTRIES_W-1:0] r_alloc_ptr;

  logic                         w_hit, w_src_hit, w_free;
  logic [NUM_BTB_ENTRIES_W-1:0] w_hit_idx, w_src_idx, w_free_idx, w_alloc_idx;
  logic [NUM_BHT_ENTRIES_W-1:0] w_bht_idx, w_src_bht_idx;
  logic [BTB_TYPE_W-1:0]        w_type, w_upd_type;
  logic [31:0]                  w_pred_tgt, w_ras_top;
  logic                         w_pred_taken, w_ras_empty;
  logic                         w_upd_taken, w_upd_nt, w_upd_cond;

  always_comb begin
    w_hit = 1'b0; w_hit_idx = '0;
    w_src_hit = 1'b0; w_src_idx = '0;
    w_free = 1'b0; w_free_idx = '0;
    for (int unsigned i = 0; i < NUM_BTB_ENTRIES; i++) begin
      if (r_btb_valid[i] && r_btb_pc[i] == bus.pc_f_i) begin
        w_hit = 1'b1; w_hit_idx = i[NUM_BTB_ENTRIES_W-1:0];
      end
      if (r_btb_valid[i] && r_btb_pc[i] == bus.branch_source_i) begin
        w_src_hit = 1'b1; w_src_idx = i[NUM_BTB_ENTRIES_W-1:0];
      end
      if (!r_btb_valid[i] && !w_free) begin
        w_free = 1'b1; w_free_idx = i[NUM_BTB_ENTRIES_W-1:0];
      end
    end
  end

  assign w_bht_idx     = bus.pc_f_i[NUM_BHT_ENTRIES_W+1:2];
  assign w_src_bht_idx = bus.branch_source_i[NUM_BHT_ENTRIES_W+1:2];
  assign w_type        = r_btb_type[w_hit_idx];

  always_comb begin
    w_pred_taken = 1'b0;
    w_pred_tgt   = r_btb_tgt[w_hit_idx];
    if (w_hit) begin
      if (w_type[TYPE_RET]) begin
        w_pred_taken = 1'b1;
        if (!w_ras_empty) w_pred_tgt = w_ras_top;
      end else if (w_type[TYPE_CALL] || w_type[TYPE_JMP]) begin
        w_pred_taken = 1'b1;
      end else begin
        w_pred_taken = r_bht[w_bht_idx][1];
      end
    end
  end

  // Reset masks the prediction so outputs reflect the cleared tables at once.
  always_comb begin
    bus.next_taken_f_o = 1'b0;
    bus.next_pc_f_o    = bus.pc_f_i + 32'd4;
    if (!rst_i && bus.enable_i && w_pred_taken) begin
      bus.next_taken_f_o = 1'b1;
      bus.next_pc_f_o    = w_pred_tgt;
    end
  end

  assign w_upd_taken = bus.branch_is_taken_i;
  assign w_upd_nt    = bus.branch_is_not_taken_i && !bus.branch_is_taken_i;
  assign w_upd_cond  = !(bus.branch_is_call_i || bus.branch_is_ret_i || bus.branch_is_jmp_i);
  assign w_alloc_idx = w_free ? w_free_idx : r_alloc_ptr;

  always_comb begin
    w_upd_type            = '0;
    w_upd_type[TYPE_CALL] = bus.branch_is_call_i;
    w_upd_type[TYPE_RET]  = bus.branch_is_ret_i;
    w_upd_type[TYPE_JMP]  = bus.branch_is_jmp_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NUM_BTB_ENTRIES; i++) begin
        r_btb_valid[i] <= 1'b0;
        r_btb_pc[i]    <= '0;
        r_btb_tgt[i]   <= '0;
        r_btb_type[i]  <= '0;
      end
      for (int unsigned i = 0; i < NUM_BHT_ENTRIES; i++) r_bht[i] <= BHT_RESET;
      r_alloc_ptr <= '0;
    end else if (bus.branch_request_i) begin
      if (w_upd_cond && (w_upd_taken || w_upd_nt))
        r_bht[w_src_bht_idx] <= bht_update(r_bht[w_src_bht_idx], w_upd_taken);
      if (w_upd_taken) begin
        if (w_src_hit) begin
          r_btb_tgt[w_src_idx]  <= bus.branch_pc_i;
          r_btb_type[w_src_idx] <= w_upd_type;
        end else begin
          r_btb_valid[w_alloc_idx] <= 1'b1;
          r_btb_pc[w_alloc_idx]    <= bus.branch_source_i;
          r_btb_tgt[w_alloc_idx]   <= bus.branch_pc_i;
          r_btb_type[w_alloc_idx]  <= w_upd_type;
          if (!w_free) r_alloc_ptr <= r_alloc_ptr + NUM_BTB_ENTRIES_W'(1);
        end
      end
    end
  end

  biriscv_bpred_ras #(
    .NUM_RAS_ENTRIES   (NUM_RAS_ENTRIES),
    .NUM_RAS_ENTRIES_W (NUM_RAS_ENTRIES_W)
  ) u_ras (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (bus.branch_request_i && bus.branch_is_call_i),
    .pop_i       (bus.branch_request_i && bus.branch_is_ret_i),
    .push_data_i (bus.branch_source_i + 32'd4),
    .top_data_o  (w_ras_top),
    .empty_o     (w_ras_empty)
  );

endmodule

// File: tb/tb_biriscv_bpred.sv
// Directed bench for biriscv_bpred: a vector table for the main sequence plus
// hand-written reset, RAS overflow and BTB replacement sequences.
module tb_biriscv_bpred;

  localparam logic [1:0] K_COND = 2'd0, K_CALL = 2'd1, K_RET = 2'd2, K_JMP = 2'd3;

  typedef struct {
    logic        req, tk, nt, en, exp_tk;
    logic [1:0]  kind;
    logic [31:0] src, bpc, pcf, exp_pc;
  } vec_t;

  logic clk, rst;
  int   n_pass, n_total;
  vec_t tbl[$];

  biriscv_bpred_if bus();

  biriscv_bpred #(
    .NUM_BTB_ENTRIES(16), .NUM_BTB_ENTRIES_W(4),
    .NUM_BHT_ENTRIES(256), .NUM_BHT_ENTRIES_W(8),
    .NUM_RAS_ENTRIES(8), .NUM_RAS_ENTRIES_W(3)
  ) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic req, input logic tk, input logic nt,
                              input logic [1:0] kind, input logic [31:0] src,
                              input logic [31:0] bpc, input logic en,
                              input logic [31:0] pcf, input logic [31:0] exp_pc,
                              input logic exp_tk);
    vec_t v;
    v.req = req; v.tk = tk; v.nt = nt; v.kind = kind; v.src = src; v.bpc = bpc;
    v.en = en; v.pcf = pcf; v.exp_pc = exp_pc; v.exp_tk = exp_tk;
    return v;
  endfunction

  function automatic vec_t idle(input logic [31:0] pcf, input logic [31:0] exp_pc,
                                input logic exp_tk);
    return mk(1'b0, 1'b0, 1'b0, K_COND, 32'h0, 32'h0, 1'b1, pcf, exp_pc, exp_tk);
  endfunction

  task automatic apply(input vec_t v);
    bus.enable_i              = v.en;
    bus.branch_request_i      = v.req;
    bus.branch_is_taken_i     = v.tk;
    bus.branch_is_not_taken_i = v.nt;
    bus.branch_source_i       = v.src;
    bus.branch_pc_i           = v.bpc;
    bus.branch_is_call_i      = (v.kind == K_CALL);
    bus.branch_is_ret_i       = (v.kind == K_RET);
    bus.branch_is_jmp_i       = (v.kind == K_JMP);
    bus.pc_f_i                = v.pcf;
  endtask

  task automatic check(input string name, input logic [31:0] exp_pc, input logic exp_tk);
    n_total++;
    if (bus.next_pc_f_o === exp_pc && bus.next_taken_f_o === exp_tk)
      n_pass++;
    else
      $display("FAIL %s: got next_pc=%h taken=%b, expected next_pc=%h taken=%b",
               name, bus.next_pc_f_o, bus.next_taken_f_o, exp_pc, exp_tk);
  endtask

  task automatic step(input vec_t v, input string name);
    @(negedge clk);
    apply(v);
    #1;
    check(name, v.exp_pc, v.exp_tk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    apply(idle(32'h0, 32'h4, 1'b0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    apply(idle(32'h0, 32'h4, 1'b0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Main sequence: each row is checked before the edge that applies its update.
    tbl.push_back(idle(32'h8000_0000, 32'h8000_0004, 1'b0));
    tbl.push_back(idle(32'hFFFF_FFFC, 32'h0000_0000, 1'b0));
    tbl.push_back(mk(1, 1, 0, K_COND, 32'h100, 32'h200, 1, 32'h100, 32'h104, 0));
    tbl.push_back(idle(32'h100, 32'h200, 1'b1));
    tbl.push_back(mk(1, 0, 1, K_COND, 32'h100, 32'h104, 1, 32'h100, 32'h200, 1));
    tbl.push_back(mk(1, 0, 1, K_COND, 32'h100, 32'h104, 1, 32'h100, 32'h200, 1));
    tbl.push_back(idle(32'h100, 32'h104, 1'b0));
    tbl.push_back(mk(1, 1, 0, K_COND, 32'h100, 32'h200, 1, 32'h100, 32'h104, 0));
    tbl.push_back(idle(32'h100, 32'h200, 1'b1));
    tbl.push_back(mk(0, 0, 0, K_COND, 32'h0, 32'h0, 0, 32'h100, 32'h104, 0));
    tbl.push_back(mk(1, 1, 0, K_CALL, 32'h300, 32'h400, 1, 32'h300, 32'h304, 0));
    tbl.push_back(idle(32'h300, 32'h400, 1'b1));
    tbl.push_back(mk(1, 1, 0, K_RET, 32'h410, 32'h304, 1, 32'h410, 32'h414, 0));
    tbl.push_back(mk(1, 1, 0, K_CALL, 32'h500, 32'h600, 1, 32'h410, 32'h304, 1));
    tbl.push_back(idle(32'h410, 32'h504, 1'b1));
    tbl.push_back(mk(1, 1, 0, K_JMP, 32'h700, 32'h800, 1, 32'h700, 32'h704, 0));
    tbl.push_back(idle(32'h700, 32'h800, 1'b1));
    tbl.push_back(mk(1, 0, 1, K_JMP, 32'h700, 32'h704, 1, 32'h700, 32'h800, 1));
    tbl.push_back(idle(32'h700, 32'h800, 1'b1));
    tbl.push_back(mk(1, 0, 1, K_COND, 32'h900, 32'h904, 1, 32'h900, 32'h904, 0));
    tbl.push_back(idle(32'h900, 32'h904, 1'b0));
    tbl.push_back(idle(32'h100, 32'h104, 1'b0));
    tbl.push_back(mk(1, 1, 1, K_COND, 32'h100, 32'h200, 1, 32'h100, 32'h104, 0));
    tbl.push_back(idle(32'h100, 32'h200, 1'b1));

    foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

    // Reset with a resolution pending: prediction masked, resolution dropped.
    @(negedge clk);
    rst = 1'b1;
    apply(mk(1, 1, 0, K_COND, 32'h100, 32'h200, 1, 32'h410, 32'h0, 0));
    #1;
    check("rst_cycle", 32'h414, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    apply(idle(32'h100, 32'h0, 1'b0));
    #1;
    check("rst_drop_100", 32'h104, 1'b0);
    step(idle(32'h410, 32'h414, 1'b0), "rst_clear_410");
    step(idle(32'h300, 32'h304, 1'b0), "rst_clear_300");

    // RAS overflow: nine calls into an 8-deep stack, then drain with returns.
    step(mk(1, 1, 0, K_RET, 32'h410, 32'hABC0, 1, 32'h410, 32'h414, 0), "ras_ret_alloc");
    for (int k = 0; k < 9; k++)
      step(mk(1, 1, 0, K_CALL, 32'h2000 + 32'(k) * 32'h10, 32'h3000, 1, 32'h20, 32'h24, 0),
           $sformatf("ras_push%0d", k));
    for (int p = 0; p < 8; p++)
      step(mk(1, 1, 0, K_RET, 32'h410, 32'hABC0, 1, 32'h410,
              32'h2084 - 32'(p) * 32'h10, 1), $sformatf("ras_pop%0d", p));
    step(idle(32'h410, 32'hABC0, 1'b1), "ras_empty_btb");

    // BTB replacement: 16 fills, then round-robin victims from entry 0.
    do_reset();
    for (int n = 0; n < 17; n++)
      step(mk(1, 1, 0, K_COND, 32'h1000 + 32'(n) * 4, 32'h8000 + 32'(n) * 4, 1,
              32'h20, 32'h24, 0), $sformatf("btb_fill%0d", n));
    step(idle(32'h1000, 32'h1004, 1'b0), "btb_evict0");
    step(idle(32'h1040, 32'h8040, 1'b1), "btb_new1040");
    step(idle(32'h1004, 32'h8004, 1'b1), "btb_keep1004");
    step(mk(1, 1, 0, K_COND, 32'h1044, 32'h8044, 1, 32'h20, 32'h24, 0), "btb_fill17");
    step(idle(32'h1004, 32'h1008, 1'b0), "btb_evict1");
    step(idle(32'h1044, 32'h8044, 1'b1), "btb_new1044");
    step(idle(32'h1040, 32'h8040, 1'b1), "btb_keep1040");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
